// File: rtl/acu_pkg.sv
// Shared opcode, mux-select, ALU and FSM state encodings for the accumulator control unit.
// ACU_SINGLE_STEP_EN adds the PAUSE state encoding.
package acu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_IN  = 4'h7;
    localparam logic [3:0] OP_CLR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_IMM  = 3'd2;
    localparam logic [2:0] SEL_IN   = 3'd3;
    localparam logic [2:0] SEL_ZERO = 3'd4;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOADIR = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEMRD  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
`ifdef ACU_SINGLE_STEP_EN
    localparam logic [2:0] ST_PAUSE  = 3'd6;
`endif

    // Program counter advance; the 4-bit space wraps 15 -> 0.
    function automatic logic [3:0] pc_inc(input logic [3:0] pc_val);
        return pc_val + 4'd1;
    endfunction

endpackage

// File: rtl/acu_decode.sv
// Combinational opcode decoder: instruction class flags plus the mux select and ALU op
// the instruction uses when it writes the accumulator.
module acu_decode
    import acu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_memrd,
    output logic       is_store,
    output logic       is_jump,
    output logic       is_jz,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [2:0] acc_sel,
    output logic [1:0] alu_op
);

    // Opcode to control-class decode; B..E fall into the illegal default.
    always_comb begin
        is_memrd   = 1'b0;
        is_store   = 1'b0;
        is_jump    = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        acc_sel    = SEL_ALU;
        alu_op     = ALU_PASS;
        case (opcode)
            OP_NOP: begin
                is_memrd = 1'b0;
            end
            OP_LDA: begin
                is_memrd = 1'b1;
                acc_sel  = SEL_MEM;
            end
            OP_STA: is_store = 1'b1;
            OP_ADD: begin
                is_memrd = 1'b1;
                alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                is_memrd = 1'b1;
                alu_op   = ALU_SUB;
            end
            OP_AND: begin
                is_memrd = 1'b1;
                alu_op   = ALU_AND;
            end
            OP_LDI: acc_sel = SEL_IMM;
            OP_IN:  acc_sel = SEL_IN;
            OP_CLR: acc_sel = SEL_ZERO;
            OP_JMP: is_jump = 1'b1;
            OP_JZ:  is_jz   = 1'b1;
            OP_HLT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_control_unit.sv
// Multi-cycle fetch/execute sequencer for the 8-bit accumulator processor.
// Optional ACU_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module acc_control_unit
    import acu_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef ACU_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] mem_rdata,
    input  logic       acc_zero,
    output logic [3:0] mem_addr,
    output logic       mem_re,
    output logic       mem_we,
    output logic [2:0] acc_sel,
    output logic [7:0] imm,
    output logic [1:0] alu_op,
    output logic       acc_load,
    output logic [3:0] pc,
    output logic       halted,
    output logic       illegal
);

`ifdef ACU_SINGLE_STEP_EN
    localparam logic [2:0] ST_AFTER = ST_PAUSE;
`else
    localparam logic [2:0] ST_AFTER = ST_FETCH;
`endif

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [3:0] pc_r;
    logic [3:0] pc_nxt_s;
    logic [7:0] ir_r;
    logic [7:0] ir_nxt_s;

    logic       dec_memrd_s;
    logic       dec_store_s;
    logic       dec_jump_s;
    logic       dec_jz_s;
    logic       dec_halt_s;
    logic       dec_illegal_s;
    logic [2:0] dec_acc_sel_s;
    logic [1:0] dec_alu_op_s;
    logic       dec_direct_load_s;

    acu_decode u_decode (
        .opcode     (ir_r[7:4]),
        .is_memrd   (dec_memrd_s),
        .is_store   (dec_store_s),
        .is_jump    (dec_jump_s),
        .is_jz      (dec_jz_s),
        .is_halt    (dec_halt_s),
        .is_illegal (dec_illegal_s),
        .acc_sel    (dec_acc_sel_s),
        .alu_op     (dec_alu_op_s)
    );

    // LDI/IN/CLR write the accumulator directly from EXEC without a memory read.
    assign dec_direct_load_s = !dec_memrd_s && (dec_acc_sel_s != SEL_ALU);

    // Next-state logic of the instruction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_FETCH;
                else       state_nxt_s = ST_IDLE;
            end
            ST_FETCH:  state_nxt_s = ST_LOADIR;
            ST_LOADIR: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (dec_halt_s || dec_illegal_s) state_nxt_s = ST_HALT;
                else if (dec_memrd_s)            state_nxt_s = ST_MEMRD;
                else                             state_nxt_s = ST_AFTER;
            end
            ST_MEMRD: state_nxt_s = ST_AFTER;
`ifdef ACU_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) state_nxt_s = ST_FETCH;
                else      state_nxt_s = ST_PAUSE;
            end
`endif
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Program counter and instruction register updates.
    always_comb begin
        pc_nxt_s = pc_r;
        ir_nxt_s = ir_r;
        if (state_r == ST_LOADIR) begin
            pc_nxt_s = pc_inc(pc_r);
            ir_nxt_s = mem_rdata;
        end else if ((state_r == ST_EXEC) && (dec_jump_s || (dec_jz_s && acc_zero))) begin
            pc_nxt_s = ir_r[3:0];
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
        end
    end

    // Output decode of state and instruction; strobes are quiet outside FETCH/EXEC/MEMRD.
    always_comb begin
        mem_addr = 4'h0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        acc_sel  = SEL_ALU;
        alu_op   = ALU_PASS;
        acc_load = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_addr = pc_r;
                mem_re   = 1'b1;
            end
            ST_EXEC: begin
                mem_addr = ir_r[3:0];
                mem_re   = dec_memrd_s;
                mem_we   = dec_store_s;
                if (dec_direct_load_s) begin
                    acc_load = 1'b1;
                    acc_sel  = dec_acc_sel_s;
                end else begin
                    acc_load = 1'b0;
                end
            end
            ST_MEMRD: begin
                acc_load = 1'b1;
                acc_sel  = dec_acc_sel_s;
                alu_op   = dec_alu_op_s;
            end
            ST_HALT: begin
                illegal = dec_illegal_s;
                halted  = !dec_illegal_s;
            end
            default: begin
                mem_re = 1'b0;
            end
        endcase
    end

    assign imm = {4'h0, ir_r[3:0]};
    assign pc  = pc_r;

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed bench for acc_control_unit with a small memory and accumulator datapath model.
module tb_acc_control_unit;

    typedef struct packed {
        logic [3:0] mem_addr;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] acc_sel;
        logic [7:0] imm;
        logic [1:0] alu_op;
        logic       acc_load;
        logic [3:0] pc;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic  start_in;
        outs_t exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
`ifdef ACU_SINGLE_STEP_EN
    logic       step;
`endif
    logic [7:0] mem_rdata;
    logic       acc_zero;
    logic [3:0] mem_addr;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] acc_sel;
    logic [7:0] imm;
    logic [1:0] alu_op;
    logic       acc_load;
    logic [3:0] pc;
    logic       halted;
    logic       illegal;

    logic [7:0] mem [0:15];
    logic [7:0] acc;
    logic [7:0] in_port;
    logic       ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;

    int n_cmp;
    int n_fail;

    acc_control_unit #(.RESET_PC(4'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef ACU_SINGLE_STEP_EN
        .step      (step),
`endif
        .mem_rdata (mem_rdata),
        .acc_zero  (acc_zero),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .acc_sel   (acc_sel),
        .imm       (imm),
        .alu_op    (alu_op),
        .acc_load  (acc_load),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after mem_re; tb loader port when idle.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= acc;
        else if (ld_we) mem[ld_addr] <= ld_data;
    end

    // Accumulator datapath model.
    always @(posedge clk or posedge reset) begin
        if (reset) acc <= 8'h00;
        else if (acc_load) begin
            case (acc_sel)
                3'd0: begin
                    case (alu_op)
                        2'b00:   acc <= acc + mem_rdata;
                        2'b01:   acc <= acc - mem_rdata;
                        2'b10:   acc <= acc & mem_rdata;
                        default: acc <= acc;
                    endcase
                end
                3'd1:    acc <= mem_rdata;
                3'd2:    acc <= imm;
                3'd3:    acc <= in_port;
                default: acc <= 8'h00;
            endcase
        end
    end
    assign acc_zero = (acc == 8'h00);

    function automatic outs_t mk(input logic [3:0] a, input logic re, input logic we,
                                 input logic [2:0] sel, input logic [7:0] im, input logic [1:0] op,
                                 input logic ld, input logic [3:0] p, input logic h, input logic il);
        outs_t o;
        o.mem_addr = a; o.mem_re = re; o.mem_we = we; o.acc_sel = sel; o.imm = im;
        o.alu_op = op; o.acc_load = ld; o.pc = p; o.halted = h; o.illegal = il;
        return o;
    endfunction

    function automatic outs_t obs();
        return mk(mem_addr, mem_re, mem_we, acc_sel, imm, alu_op, acc_load, pc, halted, illegal);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    // Hold reset, fill memory with HLT and check the reset output state.
    task automatic prep();
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) load_word(i[3:0], 8'hF0);
        check("reset_outputs", {6'd0, obs()}, {6'd0, mk(4'h0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b11, 1'b0, 4'h0, 1'b0, 1'b0)});
    endtask

    // Release reset, pulse start for one cycle; returns at the first FETCH cycle (c0).
    task automatic release_and_start();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    vec_t vec [16];

    initial begin
        int   cyc;
        logic seen;
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        in_port = 8'h00;
        ld_we   = 1'b0;
        ld_addr = 4'h0;
        ld_data = 8'h00;
`ifdef ACU_SINGLE_STEP_EN
        step    = 1'b0;
`endif

        // LDA 14; ADD 15; STA 13; HLT, cycle by cycle from the first FETCH.
        vec[0]  = '{1'b0, mk(4'd0,  1'b1, 1'b0, 3'd0, 8'd0,  2'b11, 1'b0, 4'd0, 1'b0, 1'b0)};
        vec[1]  = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd0,  2'b11, 1'b0, 4'd0, 1'b0, 1'b0)};
        vec[2]  = '{1'b0, mk(4'd14, 1'b1, 1'b0, 3'd0, 8'd14, 2'b11, 1'b0, 4'd1, 1'b0, 1'b0)};
        vec[3]  = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd1, 8'd14, 2'b11, 1'b1, 4'd1, 1'b0, 1'b0)};
        vec[4]  = '{1'b0, mk(4'd1,  1'b1, 1'b0, 3'd0, 8'd14, 2'b11, 1'b0, 4'd1, 1'b0, 1'b0)};
        vec[5]  = '{1'b1, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd14, 2'b11, 1'b0, 4'd1, 1'b0, 1'b0)};
        vec[6]  = '{1'b0, mk(4'd15, 1'b1, 1'b0, 3'd0, 8'd15, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0)};
        vec[7]  = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd15, 2'b00, 1'b1, 4'd2, 1'b0, 1'b0)};
        vec[8]  = '{1'b0, mk(4'd2,  1'b1, 1'b0, 3'd0, 8'd15, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0)};
        vec[9]  = '{1'b1, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd15, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0)};
        vec[10] = '{1'b0, mk(4'd13, 1'b0, 1'b1, 3'd0, 8'd13, 2'b11, 1'b0, 4'd3, 1'b0, 1'b0)};
        vec[11] = '{1'b0, mk(4'd3,  1'b1, 1'b0, 3'd0, 8'd13, 2'b11, 1'b0, 4'd3, 1'b0, 1'b0)};
        vec[12] = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd13, 2'b11, 1'b0, 4'd3, 1'b0, 1'b0)};
        vec[13] = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd0,  2'b11, 1'b0, 4'd4, 1'b0, 1'b0)};
        vec[14] = '{1'b0, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd0,  2'b11, 1'b0, 4'd4, 1'b1, 1'b0)};
        vec[15] = '{1'b1, mk(4'd0,  1'b0, 1'b0, 3'd0, 8'd0,  2'b11, 1'b0, 4'd4, 1'b1, 1'b0)};

`ifndef ACU_SINGLE_STEP_EN
        prep();
        load_word(4'd0, 8'h1E);
        load_word(4'd1, 8'h3F);
        load_word(4'd2, 8'h2D);
        load_word(4'd13, 8'hAA);
        load_word(4'd14, 8'h03);
        load_word(4'd15, 8'h04);
        release_and_start();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("trace_c%0d", i), {6'd0, obs()}, {6'd0, vec[i].exp});
            start = vec[i].start_in;
            @(negedge clk);
        end
        start = 1'b0;
        check("sta_result_mem13", mem[13], 8'h07);

        // LDI 5; HLT
        prep();
        load_word(4'd0, 8'h65);
        load_word(4'd1, 8'hF0);
        release_and_start();
        adv(2);
        check("ldi_exec_load", {acc_load, acc_sel, imm}, {1'b1, 3'd2, 8'h05});
        cyc = 2;
        while (!halted && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ldi_hlt_cycles", cyc, 6);
        check("ldi_hlt_pc", pc, 4'd2);
        check("ldi_acc", acc, 8'h05);

        // LDI 3; CLR; JZ 7 -> jump taken
        prep();
        load_word(4'd0, 8'h63);
        load_word(4'd1, 8'h80);
        load_word(4'd2, 8'hA7);
        release_and_start();
        adv(5);
        check("clr_exec", {acc_load, acc_sel}, {1'b1, 3'd4});
        adv(4);
        check("jz_taken", {pc, mem_addr, mem_re}, {4'd7, 4'd7, 1'b1});

        // IN (nonzero); JZ 7 -> not taken
        prep();
        in_port = 8'h09;
        load_word(4'd0, 8'h70);
        load_word(4'd1, 8'hA7);
        release_and_start();
        adv(6);
        check("jz_not_taken", {pc, mem_addr, mem_re}, {4'd2, 4'd2, 1'b1});
        check("in_acc", acc, 8'h09);

        // JMP 0 at address 0: tight loop
        prep();
        load_word(4'd0, 8'h90);
        release_and_start();
        adv(3);
        check("jmp_self", {pc, mem_addr, mem_re}, {4'd0, 4'd0, 1'b1});

        // JMP 15; NOP at 15 -> next fetch wraps to 0
        prep();
        load_word(4'd0, 8'h9F);
        load_word(4'd15, 8'h00);
        release_and_start();
        adv(3);
        check("fetch_pc15", {pc, mem_addr}, {4'd15, 4'd15});
        adv(3);
        check("pc_wrap", {pc, mem_addr, mem_re}, {4'd0, 4'd0, 1'b1});

        // Opcode 0xC at address 0 -> illegal halt, no writes ever
        prep();
        load_word(4'd0, 8'hC0);
        release_and_start();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | acc_load | mem_we;
            @(negedge clk);
        end
        check("illegal_flags", {illegal, halted}, {1'b1, 1'b0});
        check("illegal_no_load_we", seen, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        adv(3);
        check("halt_ignores_start", {illegal, mem_re, pc}, {1'b1, 1'b0, 4'd1});

        // Reset during EXEC of STA aborts the write
        prep();
        load_word(4'd0, 8'h2D);
        load_word(4'd13, 8'h55);
        release_and_start();
        in_port = 8'h00;
        adv(2);
        check("sta_exec_we", {mem_we, mem_addr}, {1'b1, 4'd13});
        #1 reset = 1'b1;
        #1;
        check("reset_async_abort", {mem_we, pc, mem_addr, mem_re}, {1'b0, 4'd0, 4'd0, 1'b0});
        adv(2);
        check("no_partial_write", mem[13], 8'h55);
        release_and_start();
        check("restart_fetch", {mem_addr, mem_re, pc}, {4'd0, 1'b1, 4'd0});
`else
        // Single step: NOP; NOP; HLT
        prep();
        load_word(4'd0, 8'h00);
        load_word(4'd1, 8'h00);
        load_word(4'd2, 8'hF0);
        release_and_start();
        adv(3);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | mem_re | mem_we | acc_load;
            @(negedge clk);
        end
        check("pause_quiet", {seen, pc}, {1'b0, 4'd1});
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step1_fetch", {mem_addr, mem_re}, {4'd1, 1'b1});
        adv(5);
        check("pause2_hold", {pc, mem_re, mem_we}, {4'd2, 1'b0, 1'b0});
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step2_fetch", {mem_addr, mem_re}, {4'd2, 1'b1});
        adv(3);
        check("step_halt", {halted, pc}, {1'b1, 4'd3});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
